// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oled_pkg
// Purpose  : Shared constants and state encoding for the OLED frame link.
//            Used by both the transmitter and the receiving display block.
// Revision : 1.0 - initial release
// ============================================================================
package oled_pkg;

  // Bytes in one full frame and the address width needed to reach them
  localparam int FRAME_BYTES = 1024;
  localparam int ADDR_W      = 10;

  // Transmitter FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/oled_slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : oled_slot_timer
// Purpose  : Byte-slot timing. One slot is 2*CLK_DIV cycles: CLK_DIV cycles
//            with the strobe low followed by CLK_DIV cycles with it high.
//            Provides the strobe phase and slot start/end pulses.
// Revision : 1.0 - initial release
// ============================================================================
module oled_slot_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,        // first cycle of a frame follows
  input  logic i_run,         // a frame is in progress this cycle
  output logic o_phase_hi,    // strobe level for this cycle
  output logic o_slot_start,  // first cycle of a slot
  output logic o_slot_end     // last cycle of a slot
);

  localparam int                 c_cnt_w = $clog2(2 * CLK_DIV);
  localparam logic [c_cnt_w-1:0] c_top   = c_cnt_w'(2 * CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(CLK_DIV);

  logic [c_cnt_w-1:0] r_cnt;

  // Down-counter: loaded to the top at frame start, reloaded at every slot
  // end while running, parked at zero otherwise.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= c_top;
    end else if (i_run) begin
      r_cnt <= (r_cnt == '0) ? c_top : r_cnt - 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  // Upper half of the count is the low phase, lower half the high phase
  assign o_phase_hi   = i_run && (r_cnt < c_half);
  assign o_slot_start = i_run && (r_cnt == c_top);
  assign o_slot_end   = i_run && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/oled_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : oled_frame_tx
// Purpose  : Streams one framebuffer to an OLED link: CMD_BYTES zero preamble
//            bytes with dc low, then 1024 frame bytes with dc high, read from
//            a synchronous RAM with one slot of address prefetch.
// Revision : 1.0 - initial release
// ============================================================================
module oled_frame_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int CMD_BYTES = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_fb_raddr,
  input  logic [7:0]        i_fb_rdata,
  output logic              o_oled_clk,
  output logic              o_oled_dc,
  output logic [7:0]        o_oled_data,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [3:0]        c_cmd_last  = 4'(CMD_BYTES);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FRAME_BYTES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cmd_cnt;   // preamble slots started so far
  logic [ADDR_W-1:0] r_byte_cnt;  // index of the current data slot
  logic [ADDR_W-1:0] r_raddr;
  logic [7:0]        r_data;      // byte shown in the current data slot

  logic w_busy;
  logic w_load;
  logic w_phase_hi;
  logic w_slot_start;
  logic w_slot_end;
  logic w_cmd_end;
  logic w_data_end;
  logic w_fetch;

  assign w_busy = (r_state == ST_CMD) || (r_state == ST_DATA);
  assign w_load = (r_state == ST_IDLE) && i_start;

  oled_slot_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (w_load),
    .i_run        (w_busy),
    .o_phase_hi   (w_phase_hi),
    .o_slot_start (w_slot_start),
    .o_slot_end   (w_slot_end)
  );

  assign w_cmd_end  = (r_state == ST_CMD) && w_slot_end && (r_cmd_cnt == c_cmd_last);
  assign w_data_end = (r_state == ST_DATA) && w_slot_end && (r_byte_cnt == c_last_addr);
  // Capture the next byte at every slot boundary that leads into a data slot
  assign w_fetch    = w_cmd_end || ((r_state == ST_DATA) && w_slot_end && !w_data_end);

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start)    w_next = ST_CMD;
      ST_CMD:  if (w_cmd_end)  w_next = ST_DATA;
      ST_DATA: if (w_data_end) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Preamble slot counter, advanced as each CMD slot begins
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cmd_cnt <= '0;
    end else if (r_state == ST_CMD) begin
      if (w_slot_start) r_cmd_cnt <= r_cmd_cnt + 1'b1;
    end else begin
      r_cmd_cnt <= '0;
    end
  end

  // Data slot index; cleared on the last slot so it never wraps
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_byte_cnt <= '0;
    end else if (r_state == ST_DATA) begin
      if (w_slot_end) r_byte_cnt <= w_data_end ? '0 : r_byte_cnt + 1'b1;
    end else begin
      r_byte_cnt <= '0;
    end
  end

  // Read address runs one byte ahead of the slot on screen, so the RAM
  // latency is hidden inside the current slot; it saturates at the last
  // address and rests at 0 between frames.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_raddr <= '0;
    end else if (!w_busy || w_data_end) begin
      r_raddr <= '0;
    end else if (w_fetch) begin
      r_raddr <= (r_raddr == c_last_addr) ? r_raddr : r_raddr + 1'b1;
    end
  end

  // Byte register loaded at the boundary into each data slot
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_data <= '0;
    end else if (w_fetch) begin
      r_data <= i_fb_rdata;
    end else if (r_state != ST_DATA) begin
      r_data <= '0;
    end
  end

  assign o_fb_raddr  = r_raddr;
  assign o_oled_clk  = w_phase_hi;
  assign o_oled_dc   = (r_state == ST_DATA);
  assign o_oled_data = (r_state == ST_DATA) ? r_data : 8'h00;
  assign o_busy      = w_busy;
  assign o_done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_oled_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_frame_tx
// Purpose  : Directed self-checking bench. Instance A uses CLK_DIV=2,
//            CMD_BYTES=1; instance B uses CLK_DIV=1, CMD_BYTES=3. A link
//            monitor acts as the receiver and gathers per-frame statistics.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oled_frame_tx;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [9:0] raddr_a, raddr_b;
  logic [7:0] rdata_a, rdata_b;
  logic       oc_a, oc_b, dc_a, dc_b, busy_a, busy_b, done_a, done_b;
  logic [7:0] d_a, d_b;
  logic       mon_clr;

  logic [7:0] mem [2][1024];
  logic [7:0] rx  [2][1024];

  int cyc;
  int busy_cyc[2], busy_start[2], last_done[2], last_edge[2];
  int done_cnt[2], cmd_edges[2], dat_edges[2], fr_dat[2], last_d[2];
  int idle_bad[2], stab_bad[2], space_bad[2], cmd_bad[2];
  int gap_n[2], gap_bad[2], max_ra[2];
  logic p_oc[2], p_dc[2], p_busy[2];
  logic [7:0] p_d[2];

  int n_cmp;
  int n_err;

  oled_frame_tx #(.CLK_DIV(2), .CMD_BYTES(1)) u_dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(start_a),
    .o_fb_raddr(raddr_a), .i_fb_rdata(rdata_a),
    .o_oled_clk(oc_a), .o_oled_dc(dc_a), .o_oled_data(d_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  oled_frame_tx #(.CLK_DIV(1), .CMD_BYTES(3)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(start_b),
    .o_fb_raddr(raddr_b), .i_fb_rdata(rdata_b),
    .o_oled_clk(oc_b), .o_oled_dc(dc_b), .o_oled_data(d_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous framebuffer RAMs
  always @(posedge clk) begin
    rdata_a <= mem[0][raddr_a];
    rdata_b <= mem[1][raddr_b];
  end

  task automatic clear_stats();
    for (int g = 0; g < 2; g++) begin
      busy_cyc[g] = 0; busy_start[g] = 0; last_done[g] = -1; last_edge[g] = -1;
      done_cnt[g] = 0; cmd_edges[g] = 0; dat_edges[g] = 0; fr_dat[g] = 0;
      last_d[g] = 0; idle_bad[g] = 0; stab_bad[g] = 0; space_bad[g] = 0;
      cmd_bad[g] = 0; gap_n[g] = 0; gap_bad[g] = 0; max_ra[g] = 0;
    end
  endtask

  task automatic mon_step(input int g, input logic oc, input logic dc,
                          input logic [7:0] d, input logic bz, input logic dn,
                          input logic [9:0] ra);
    int per;
    per = (g == 0) ? 4 : 2;
    if (bz) begin
      busy_cyc[g]++;
      if (!p_busy[g]) begin
        busy_start[g] = cyc;
        last_edge[g]  = -1;
        fr_dat[g]     = 0;
        if (last_done[g] >= 0) begin
          gap_n[g]++;
          if (cyc - last_done[g] != 2) gap_bad[g]++;
        end
      end
    end else if (oc || dc || d != 8'h00) begin
      idle_bad[g]++;
    end
    if (dn) begin
      done_cnt[g]++;
      last_done[g] = cyc;
      if (bz) idle_bad[g]++;
    end
    if (int'(ra) > max_ra[g]) max_ra[g] = int'(ra);
    if (bz && p_busy[g] && (dc != p_dc[g] || d != p_d[g]) && !(p_oc[g] && !oc))
      stab_bad[g]++;
    if (oc && !p_oc[g]) begin
      if (last_edge[g] >= 0 && cyc - last_edge[g] != per) space_bad[g]++;
      last_edge[g] = cyc;
      if (!dc) begin
        cmd_edges[g]++;
        if (d != 8'h00 || fr_dat[g] > 0) cmd_bad[g]++;
      end else begin
        if (dat_edges[g] < 1024) rx[g][dat_edges[g]] = d;
        dat_edges[g]++;
        fr_dat[g]++;
        last_d[g] = int'(d);
      end
    end
    p_oc[g] = oc; p_dc[g] = dc; p_d[g] = d; p_busy[g] = bz;
  endtask

  // Receiver / link monitor, sampled on the falling clock edge
  always @(negedge clk) begin
    cyc++;
    if (mon_clr === 1'b1) begin
      clear_stats();
    end else begin
      mon_step(0, oc_a, dc_a, d_a, busy_a, done_a, raddr_a);
      mon_step(1, oc_b, dc_b, d_b, busy_b, done_b, raddr_b);
    end
  end

  task automatic check_val(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int g, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (done_cnt[g] < n && k < budget) begin
      tick(1);
      k++;
    end
    check_val(tag, done_cnt[g], n);
  endtask

  task automatic rx_bad(input int g, output int nb);
    nb = 0;
    for (int i = 0; i < 1024; i++)
      if (rx[g][i] !== mem[g][i]) nb++;
  endtask

  initial begin
    int nb;
    int k;
    n_cmp = 0; n_err = 0; cyc = 0;
    mon_clr = 1'b0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      mem[0][i] = 8'(i);
      mem[1][i] = 8'(i * 7 + 3);
    end
    mem[1][0]    = 8'h5A;
    mem[1][1023] = 8'hA5;

    // Reset state
    tick(3);
    check_val("rst_clk",   int'(oc_a),    0);
    check_val("rst_busy",  int'(busy_a),  0);
    check_val("rst_raddr", int'(raddr_a), 0);
    check_val("rst_dc_b",  int'(dc_b),    0);
    rst = 1'b0;

    // Quiet link with start low
    clr_mon();
    tick(100);
    check_val("idle_bad",  idle_bad[0] + idle_bad[1], 0);
    check_val("idle_busy", busy_cyc[0] + busy_cyc[1], 0);
    check_val("idle_done", done_cnt[0] + done_cnt[1], 0);
    check_val("idle_ra",   max_ra[0] + max_ra[1],     0);

    // Frame on A, with a stray start pulse mid-frame
    clr_mon();
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(2000);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_done(0, 1, 5000, "a_tmo");
    tick(5);
    check_val("a_cmd",    cmd_edges[0], 1);
    check_val("a_dat",    dat_edges[0], 1024);
    check_val("a_busy",   busy_cyc[0],  4100);
    check_val("a_done",   done_cnt[0],  1);
    check_val("a_dlat",   last_done[0] - busy_start[0], 4100);
    check_val("a_space",  space_bad[0], 0);
    check_val("a_stab",   stab_bad[0],  0);
    check_val("a_cmdbad", cmd_bad[0],   0);
    check_val("a_idle",   idle_bad[0],  0);
    rx_bad(0, nb);
    check_val("a_rxbuf",  nb, 0);
    check_val("a_rx255",  int'(rx[0][255]),  255);
    check_val("a_rx256",  int'(rx[0][256]),  0);
    check_val("a_rx1023", int'(rx[0][1023]), 255);
    check_val("a_maxra",  max_ra[0], 1023);

    // Frame on B (CLK_DIV=1, three preamble bytes)
    clr_mon();
    start_b = 1'b1; tick(1); start_b = 1'b0;
    wait_done(1, 1, 3000, "b_tmo");
    tick(3);
    check_val("b_cmd",   cmd_edges[1], 3);
    check_val("b_dat",   dat_edges[1], 1024);
    check_val("b_busy",  busy_cyc[1],  2054);
    rx_bad(1, nb);
    check_val("b_rxbuf", nb, 0);
    check_val("b_first", int'(rx[1][0]), 'h5A);
    check_val("b_last",  last_d[1],      'hA5);
    check_val("b_maxra", max_ra[1], 1023);
    check_val("b_space", space_bad[1], 0);
    check_val("b_stab",  stab_bad[1],  0);

    // Start held high: back-to-back frames
    clr_mon();
    start_b = 1'b1;
    wait_done(1, 3, 8000, "c_tmo");
    start_b = 1'b0;
    tick(5);
    check_val("c_done",   done_cnt[1],  3);
    check_val("c_cmd",    cmd_edges[1], 9);
    check_val("c_dat",    dat_edges[1], 3072);
    check_val("c_busy",   busy_cyc[1],  6162);
    check_val("c_gaps",   gap_n[1],     2);
    check_val("c_gapbad", gap_bad[1],   0);
    check_val("c_space",  space_bad[1], 0);
    check_val("c_cmdbad", cmd_bad[1],   0);

    // Reset during data slot 500 on A
    clr_mon();
    start_a = 1'b1; tick(1); start_a = 1'b0;
    k = 0;
    while (dat_edges[0] < 501 && k < 5000) begin
      tick(1);
      k++;
    end
    check_val("r_reach", dat_edges[0], 501);
    check_val("r_pre_dc", int'(dc_a), 1);
    rst = 1'b1;
    #1;
    check_val("r_clk",   int'(oc_a),    0);
    check_val("r_dc",    int'(dc_a),    0);
    check_val("r_data",  int'(d_a),     0);
    check_val("r_busy",  int'(busy_a),  0);
    check_val("r_done",  int'(done_a),  0);
    check_val("r_raddr", int'(raddr_a), 0);
    tick(3);
    rst = 1'b0;
    tick(5);
    check_val("r_nodone", done_cnt[0], 0);
    clr_mon();
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_done(0, 1, 5000, "r_tmo");
    tick(3);
    check_val("r2_cmd",  cmd_edges[0], 1);
    check_val("r2_dat",  dat_edges[0], 1024);
    check_val("r2_busy", busy_cyc[0],  4100);
    check_val("r2_cmdbad", cmd_bad[0], 0);
    rx_bad(0, nb);
    check_val("r2_rxbuf", nb, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oled_frame_tx.md
OLED_FRAME_TX -- requirements
Module: oled_frame_tx

Interface
REQ-001 Parameter CLK_DIV, 2, clock cycles per oled_clk half-period; legal range 1..255.
REQ-002 Parameter CMD_BYTES, 1, number of dc-low preamble strobes sent before frame data; legal range 1..15.
REQ-003 clock  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 fb_raddr  output  10  framebuffer read address, registered.
REQ-007 fb_rdata  input  8  framebuffer read data, valid exactly one clock after fb_raddr changes (synchronous RAM).
REQ-008 oled_clk  output  1  byte strobe; the receiver samples on its rising edge.
REQ-009 oled_dc  output  1  0 = command/preamble byte (receiver address reset), 1 = frame data byte.
REQ-010 oled_data  output  8  byte value for the current slot.
REQ-011 busy  output  1  high from the first slot until the last slot ends.
REQ-012 done  output  1  single-cycle pulse at frame completion.

Function
REQ-013 The FSM SHALL have states IDLE, CMD, DATA and DONE.
REQ-014 IDLE SHALL go to CMD on the cycle after start is sampled high; start in any other state SHALL be ignored.
REQ-015 Each byte slot SHALL last 2*CLK_DIV cycles: CLK_DIV cycles with oled_clk=0, then CLK_DIV cycles with oled_clk=1.
REQ-016 oled_dc and oled_data SHALL change only at slot start and SHALL stay stable for the whole slot.
REQ-017 CMD SHALL emit CMD_BYTES slots with oled_dc=0 and oled_data=8'h00, then go to DATA.
REQ-018 DATA SHALL emit 1024 slots with oled_dc=1; in slot i, oled_data SHALL equal the framebuffer byte at address i, for i = 0..1023 in ascending order.
REQ-019 fb_raddr SHALL be prefetched so the byte for slot i is registered before slot i starts; no slot SHALL be stretched for fetch latency.
REQ-020 fb_raddr SHALL never exceed 1023 and SHALL return to 0 in IDLE; the 10-bit byte counter SHALL not wrap inside a frame.
REQ-021 After the high phase of the last DATA slot, the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-022 If start is high during DONE, it SHALL NOT be taken; it SHALL be sampled in the following IDLE cycle. Back-to-back frames SHALL therefore be separated by exactly one IDLE cycle.
REQ-023 busy SHALL be 1 in CMD and DATA and 0 in IDLE and DONE.
REQ-024 Frame length from the first CMD cycle to the last DATA cycle SHALL be (CMD_BYTES+1024)*2*CLK_DIV cycles.
REQ-025 In IDLE and DONE, oled_clk, oled_dc and oled_data SHALL all be 0.
REQ-026 Slot timing SHALL use a down-counter of width ceil(log2(2*CLK_DIV)); all other counts SHALL use fixed widths with no truncation.

Reset
REQ-027 While reset is high, the block SHALL immediately force: state=IDLE, oled_clk=0, oled_dc=0, oled_data=0, fb_raddr=0, busy=0, done=0, and all counters to 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no done pulse; the next start SHALL begin again from the CMD preamble.

Structure
REQ-029 FRAME_BYTES (1024), ADDR_W (10) and the state encoding SHALL live in the shared package oled_pkg, which the receiving display block also uses.
REQ-030 Slot timing (the oled_clk phase counter and the slot_start/slot_end strobes) SHALL be one sub-module, oled_slot_timer; the FSM and prefetch logic SHALL stay in oled_frame_tx.

Verification
REQ-031 Reset released, start=0 for 100 cycles -> oled_clk, oled_dc, oled_data, busy, done and fb_raddr all 0 throughout.
REQ-032 CLK_DIV=2, CMD_BYTES=1, RAM mem[i]=i[7:0], 1-cycle start pulse -> exactly 1 dc=0 rising edge with data 8'h00, then 1024 dc=1 rising edges carrying 00,01,...,FF repeated four times. busy is high for 4100 cycles and done pulses on the next cycle. A receiver model's buffer equals the RAM contents.
REQ-033 CLK_DIV=1, CMD_BYTES=3 -> 3 dc=0 edges, then 1024 dc=1 edges at one rising edge per 2 cycles; busy is high for 2054 cycles.
REQ-034 start held high continuously -> consecutive frames, each first CMD slot starting 2 cycles after the previous done pulse; pulsing start mid-frame has no effect on edge count or timing.
REQ-035 reset asserted during DATA slot 500 -> all outputs 0 in the same cycle and no done pulse; the next start produces a full, correct frame beginning with the dc=0 preamble.
REQ-036 mem[1023]=8'hA5, mem[0]=8'h5A -> the first data edge carries 5A, the last carries A5, and fb_raddr never exceeds 1023.
